// File: rtl/led_rotate_ctrl.sv
// LED rotation controller: synchronised switches/buttons, IDLE/RUN/PAUSE FSM, prescaled rotating LED pattern.
// Optional button debounce is compiled in with macro LED_ROTATE_CTRL_DEBOUNCE_EN.
module led_rotate_ctrl #(
   parameter int WIDTH           = 8,
   parameter int TICK_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           switches,
   input  logic                       start,
   input  logic                       pause,
   input  logic                       stop,
   input  logic                       dir,
   output logic [WIDTH-1:0]           leds,
   output logic [$clog2(WIDTH)-1:0]   shift_amt,
   output logic [1:0]                 state,
   output logic                       wrap
);

   localparam int AW = $clog2(WIDTH);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH - 1);
   localparam logic [PW-1:0] DIV_MAX = PW'(TICK_DIV - 1);
   localparam logic [AW:0]   WIDTH_X = (AW + 1)'(WIDTH);

   // Edges stay masked until the edge detector holds the true post-reset level.
`ifdef LED_ROTATE_CTRL_DEBOUNCE_EN
   localparam logic [2:0] PRIME_LEN = 3'd4;
`else
   localparam logic [2:0] PRIME_LEN = 3'd3;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t           cur_state;
   state_t           nxt_state;

   logic [WIDTH-1:0] sw_meta;
   logic [WIDTH-1:0] sw_sync;
   logic [3:0]       btn_meta;
   logic [3:0]       btn_sync;
   logic             dir_sync;

   logic [2:0]       prime_cnt;
   logic             primed;
   logic [2:0]       btn_level;
   logic [2:0]       btn_prev;
   logic [2:0]       btn_edge;
   logic             start_edge;
   logic             pause_edge;
   logic             stop_edge;

   logic [WIDTH-1:0] pattern;
   logic [PW-1:0]    presc;
   logic             tick;
   logic [WIDTH-1:0] rotated;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         btn_meta <= '0;
         btn_sync <= '0;
      end else begin
         sw_meta  <= switches;
         sw_sync  <= sw_meta;
         btn_meta <= {dir, stop, pause, start};
         btn_sync <= btn_meta;
      end
   end

   assign dir_sync = btn_sync[3];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prime_cnt <= '0;
      end else if (!primed) begin
         prime_cnt <= prime_cnt + 1'b1;
      end
   end

   assign primed = (prime_cnt == PRIME_LEN);

`ifdef LED_ROTATE_CTRL_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

   logic [DW-1:0] deb_cnt [3];
   logic [2:0]    deb_level;

   // While priming, the debounced level follows the synchroniser so held buttons never look like edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_level <= '0;
         for (int b = 0; b < 3; b++) begin
            deb_cnt[b] <= '0;
         end
      end else begin
         for (int b = 0; b < 3; b++) begin
            if (!primed) begin
               deb_level[b] <= btn_sync[b];
               deb_cnt[b]   <= '0;
            end else if (btn_sync[b] == deb_level[b]) begin
               deb_cnt[b]   <= '0;
            end else if (deb_cnt[b] == DEB_MAX) begin
               deb_level[b] <= btn_sync[b];
               deb_cnt[b]   <= '0;
            end else begin
               deb_cnt[b]   <= deb_cnt[b] + 1'b1;
            end
         end
      end
   end

   assign btn_level = deb_level;
`else
   assign btn_level = btn_sync[2:0];
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_prev <= '0;
      end else begin
         btn_prev <= btn_level;
      end
   end

   assign btn_edge   = btn_level & ~btn_prev & {3{primed}};
   assign start_edge = btn_edge[0];
   assign pause_edge = btn_edge[1];
   assign stop_edge  = btn_edge[2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Stop beats pause, pause beats start; a pause edge suppresses start even where it has no effect itself.
   always_comb begin
      nxt_state = cur_state;
      if (stop_edge) begin
         nxt_state = IDLE;
      end else if (pause_edge) begin
         if (cur_state == RUN) begin
            nxt_state = PAUSE;
         end
      end else if (start_edge && (cur_state != RUN)) begin
         nxt_state = RUN;
      end
   end

   assign tick  = (cur_state == RUN) && (presc == DIV_MAX);
   assign state = cur_state;

   always_comb begin : rotate
      logic [AW:0] src;
      src     = '0;
      rotated = '0;
      for (int i = 0; i < WIDTH; i++) begin
         src = (AW + 1)'(i) + WIDTH_X - {1'b0, shift_amt};
         if (src >= WIDTH_X) begin
            src = src - WIDTH_X;
         end
         rotated[i] = pattern[src[AW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pattern   <= '0;
         presc     <= '0;
         shift_amt <= '0;
         wrap      <= 1'b0;
         leds      <= '0;
      end else begin
         if (cur_state != RUN) begin
            pattern <= sw_sync;
         end

         if (nxt_state == IDLE) begin
            presc <= '0;
         end else if (cur_state == RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
         end

         wrap <= 1'b0;
         if (nxt_state == IDLE) begin
            shift_amt <= '0;
         end else if (tick) begin
            if (!dir_sync) begin
               shift_amt <= (shift_amt == AMT_MAX) ? '0 : shift_amt + 1'b1;
               wrap      <= (shift_amt == AMT_MAX);
            end else begin
               shift_amt <= (shift_amt == '0) ? AMT_MAX : shift_amt - 1'b1;
               wrap      <= (shift_amt == '0);
            end
         end

         leds <= rotated;
      end
   end

endmodule
